mul_datapath: RTL and testbench
===============================

Name: mul_datapath

Overview:
- Datapath for the repeated-addition multiplier. It is the direct downstream consumer of the multiplier controller's lda/ldb/ldp/clrp/decb/flag strobes.
- Holds multiplicand A, multiplier down-counter B and product accumulator P, and returns the eqz status to the controller.
- On the controller's completion flag it captures the product into an output register. The result is presented to the consumer through a valid/ready handshake.

Parameters:
- W, 8, operand width (data_in, A, B).
- PW, 16, accumulator/product width; must be >= W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  W  shared operand bus; sampled by lda/ldb.
- lda  input  1  load A from data_in.
- ldb  input  1  load B from data_in.
- ldp  input  1  accumulate P <= P + A.
- clrp  input  1  clear P and ovf.
- decb  input  1  decrement B.
- flag  input  1  controller completion level.
- eqz  output  1  B == 0, combinational from the B register.
- product  output  PW  captured result.
- ovf  output  1  sticky accumulator carry-out.
- result_valid  output  1  product holds an unconsumed result.
- result_ready  input  1  consumer accepts product.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high; the clock port is clk and the reset port is rst.
- Reset values: A=0, B=0, P=0, product=0, ovf=0, result_valid=0, flag_d=0. Consequently eqz=1 while in reset.
- A register: on lda, A <= data_in (1-cycle latency). A is otherwise held.
- B register:
  - ldb has priority over decb: B <= data_in.
  - decb with B != 0: B <= B - 1.
  - decb with B == 0: B holds at 0. B never wraps.
- eqz: combinational (B == 0). No register stage; the controller samples eqz on the same edge B is observed.
- P accumulator:
  - clrp has priority over ldp: P <= 0 and ovf <= 0.
  - ldp with eqz=0: P <= (P + zero-extended A) mod 2^PW. ovf is set if the add carries out of bit PW-1.
  - ldp with eqz=1 is ignored (P holds). ldp and decb are therefore both gated by the same B != 0 condition. The result is P = A*B exactly, even though the controller keeps ldp/decb asserted for the cycle in which eqz rises.
- Simultaneous ldp+decb, the normal accumulate state: both act on the same edge. Both use the pre-edge B for the eqz gate.
- lda and ldb in the same cycle: both load the same data_in value. This is legal, but the controller never issues it.
- Completion capture:
  - flag_d registers flag; the capture event is rise = flag & ~flag_d.
  - On rise: product <= P (the value after the final accumulate edge) and result_valid <= 1.
  - Latency is 1 cycle from flag going high to result_valid high.
- Handshake:
  - result_valid stays high, with product stable, until a cycle where result_valid & result_ready. It clears on that edge.
  - result_ready while result_valid=0 has no effect.
  - A rise while result_valid=1 overwrites product and result_valid stays 1. This includes a rise in the same cycle as a consuming ready; capture wins over clear.
- A flag held high (controller parked in its done state) produces exactly one capture.
- Reset mid-operation: all registers return to their reset values immediately. No partial product is presented, and the next run starts clean.
- No internal state machine beyond the flag edge detector and the valid flag. Sequencing is owned by the controller.

Test Plan:
- Issue lda with data_in=6, then ldb with 5 plus clrp, then hold ldp+decb. Required: B decrements 5→0; P=30; eqz rises after the 5th decrement; product=30 and result_valid=1 one cycle after flag; ovf=0.
- Run with A=7, B=0. Required: eqz=1 right after the ldb load; ldp is ignored; product=0. Then run with A=0, B=9. Required: product=0 after 9 decrements.
- Run with A=255, B=255 (W=8, PW=16). Required: product=65025, ovf=0. Additionally, hold ldp/decb for 3 extra cycles after eqz; P must stay 65025 and B must stay 0.
- Use W=8, PW=8 with A=20, B=20. Required: product=144 (400 mod 256), ovf=1. A following clrp must clear ovf to 0.
- Complete a run with result_ready held low for 10 cycles. Required: result_valid stays 1 and product stays stable throughout. Then pulse result_ready for 1 cycle. Required: result_valid=0 next cycle; flag still high causes no recapture.
- Assert rst during the accumulate phase (B=3, P=12). Required: A, B, P, product, ovf and result_valid go to 0 immediately and eqz=1. Then run a fresh 4×3. Required: product=12.

Source files
------------

// File: rtl/mul_datapath.sv
// mul_datapath: datapath for the repeated-addition multiplier.
//   Holds multiplicand A, down-counter B and accumulator P, reports eqz to the
//   controller, and captures the product on the rising edge of the controller's
//   completion flag. The captured result is offered on a valid/ready handshake.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   data_in [W]         shared operand bus, sampled by lda/ldb
//   lda, ldb            load A / load B from data_in
//   ldp, clrp           accumulate P += A / clear P and ovf (clrp wins)
//   decb                decrement B (saturates at 0)
//   flag                controller completion level
//   eqz                 B == 0, combinational
//   product [PW]        captured result
//   ovf                 sticky accumulator carry-out
//   result_valid        product holds an unconsumed result
//   result_ready        consumer accepts product
module mul_datapath #(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_in,
  input  logic          lda,
  input  logic          ldb,
  input  logic          ldp,
  input  logic          clrp,
  input  logic          decb,
  input  logic          flag,
  output logic          eqz,
  output logic [PW-1:0] product,
  output logic          ovf,
  output logic          result_valid,
  input  logic          result_ready
);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [PW-1:0] r_p;
  logic [PW-1:0] r_product;
  logic          r_ovf;
  logic          r_valid;
  logic          r_flag_d;

  logic          w_eqz;
  logic [PW:0]   w_sum;
  logic          w_rise;

  assign w_eqz  = (r_b == '0);
  // One extra bit on the adder exposes the carry out of bit PW-1.
  assign w_sum  = {1'b0, r_p} + (PW+1)'(r_a);
  assign w_rise = flag & ~r_flag_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
    end else if (lda) begin
      r_a <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b <= '0;
    end else if (ldb) begin
      r_b <= data_in;
    end else if (decb && !w_eqz) begin
      r_b <= r_b - 1'b1;
    end
  end

  // ldp shares the B != 0 gate with decb so the controller's extra strobe
  // cycle after eqz rises does not add one more A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p   <= '0;
      r_ovf <= 1'b0;
    end else if (clrp) begin
      r_p   <= '0;
      r_ovf <= 1'b0;
    end else if (ldp && !w_eqz) begin
      r_p <= w_sum[PW-1:0];
      if (w_sum[PW]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Capture on the flag's rising edge takes precedence over a consuming ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_d  <= 1'b0;
      r_product <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_flag_d <= flag;
      if (w_rise) begin
        r_product <= r_p;
        r_valid   <= 1'b1;
      end else if (r_valid && result_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign eqz          = w_eqz;
  assign product      = r_product;
  assign ovf          = r_ovf;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_mul_datapath.sv
module tb_mul_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        lda, ldb, ldp, clrp, decb, flag, result_ready;

  logic        eqz16, ovf16, valid16;
  logic [15:0] product16;
  logic        eqz8, ovf8, valid8;
  logic [7:0]  product8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_datapath #(.W(8), .PW(16)) dut16 (
    .clk(clk), .rst(rst), .data_in(data_in), .lda(lda), .ldb(ldb),
    .ldp(ldp), .clrp(clrp), .decb(decb), .flag(flag), .eqz(eqz16),
    .product(product16), .ovf(ovf16), .result_valid(valid16),
    .result_ready(result_ready)
  );

  mul_datapath #(.W(8), .PW(8)) dut8 (
    .clk(clk), .rst(rst), .data_in(data_in), .lda(lda), .ldb(ldb),
    .ldp(ldp), .clrp(clrp), .decb(decb), .flag(flag), .eqz(eqz8),
    .product(product8), .ovf(ovf8), .result_valid(valid8),
    .result_ready(result_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Acts as the controller for one multiplication.
  // mode 0: leave result unconsumed; 1: consume at once;
  // 2: hold ready low 10 cycles, then consume.
  task automatic run_mul(input int a, input int b, input int extra, input int mode);
    int          steps;
    int          full;
    logic [15:0] held16;
    full = a * b;
    @(negedge clk);
    flag = 0; result_ready = 0; ldp = 0; decb = 0; clrp = 0; ldb = 0;
    lda = 1; data_in = 8'(a);
    @(negedge clk);
    lda = 0; ldb = 1; clrp = 1; data_in = 8'(b);
    @(negedge clk);
    ldb = 0; clrp = 0;
    check("eqz_after_ldb", eqz16, (b == 0));
    check("ovf16_cleared", ovf16, 0);
    check("ovf8_cleared", ovf8, 0);
    steps = 0;
    ldp = 1; decb = 1;
    while (!eqz16 && steps < 300) begin
      @(negedge clk);
      steps++;
    end
    check("decrement_count", steps, b);
    // strobes stay up for the eqz cycle plus any extra cycles; all ignored
    repeat (1 + extra) @(negedge clk);
    check("eqz_held", eqz16, 1);
    ldp = 0; decb = 0; flag = 1;
    @(negedge clk);
    check("valid16", valid16, 1);
    check("product16", product16, full % 65536);
    check("ovf16", ovf16, (full >= 65536));
    check("valid8", valid8, 1);
    check("product8", product8, full % 256);
    check("ovf8", ovf8, (full >= 256));
    if (mode == 2) begin
      held16 = 16'(full % 65536);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("valid_held", valid16, 1);
        check("product_stable", product16, held16);
      end
    end
    if (mode != 0) begin
      result_ready = 1;
      @(negedge clk);
      result_ready = 0;
      check("valid_cleared", valid16, 0);
      check("valid8_cleared", valid8, 0);
      repeat (3) @(negedge clk);
      check("no_recapture", valid16, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; data_in = 0; lda = 0; ldb = 0; ldp = 0; clrp = 0; decb = 0;
    flag = 0; result_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_product", product16, 0);
    check("rst_valid", valid16, 0);
    check("rst_ovf", ovf16, 0);
    check("rst_eqz", eqz16, 1);
    rst = 0;

    run_mul(6, 5, 0, 1);
    run_mul(7, 0, 0, 1);
    run_mul(0, 9, 0, 1);
    run_mul(255, 255, 3, 1);
    run_mul(20, 20, 0, 1);
    @(negedge clk);
    clrp = 1;
    @(negedge clk);
    clrp = 0;
    check("clrp_ovf8", ovf8, 0);
    check("clrp_keeps_product8", product8, 144);

    run_mul(13, 11, 0, 2);

    for (int r = 0; r < 10; r++) begin
      run_mul(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 2)), 1);
    end

    // Reset mid-accumulate with an unconsumed result pending.
    run_mul(1, 1, 0, 0);
    @(negedge clk);
    flag = 0; lda = 1; data_in = 4;
    @(negedge clk);
    lda = 0; ldb = 1; clrp = 1; data_in = 6;
    @(negedge clk);
    ldb = 0; clrp = 0; ldp = 1; decb = 1;
    repeat (3) @(negedge clk);
    check("pre_rst_b", dut16.r_b, 3);
    check("pre_rst_p", dut16.r_p, 12);
    #2 rst = 1;
    #1;
    check("mid_rst_a", dut16.r_a, 0);
    check("mid_rst_b", dut16.r_b, 0);
    check("mid_rst_p", dut16.r_p, 0);
    check("mid_rst_product", product16, 0);
    check("mid_rst_ovf", ovf16, 0);
    check("mid_rst_valid", valid16, 0);
    check("mid_rst_eqz", eqz16, 1);
    @(negedge clk);
    ldp = 0; decb = 0;
    rst = 0;
    run_mul(4, 3, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
